centroid_div_feeder: RTL and testbench
======================================

CENTROID_DIV_FEEDER -- requirements
Module: centroid_div_feeder

Interface
REQ-001 SHALL have parameter K, default 8, meaning the number of clusters.
REQ-002 SHALL have parameter PIX_W, default 8, meaning the unsigned point value width.
REQ-003 SHALL have parameter CNT_W, default 8, meaning the per-cluster point count width.
REQ-004 SHALL have parameter SUM_W, default 16, meaning the per-cluster sum width.
REQ-005 SHALL have port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, width 1: reset, synchronous and active-low.
REQ-007 SHALL have port pt_valid, input, width 1: point present.
REQ-008 SHALL have port pt_data, input, width PIX_W: point value.
REQ-009 SHALL have port pt_cluster, input, width clog2(K): assigned cluster.
REQ-010 SHALL have port pt_ready, output, width 1: point accepted this cycle when high with pt_valid.
REQ-011 SHALL have port pass_end, input, width 1: pulse closing the accumulation pass.
REQ-012 SHALL have port div_in1, output, width 16: FP16 dividend (cluster sum) to the divider.
REQ-013 SHALL have port div_in2, output, width 16: FP16 divisor (cluster count) to the divider.
REQ-014 SHALL have port div_en, output, width 1: divider enable.
REQ-015 SHALL have port div_done, input, width 1: divider result valid.
REQ-016 SHALL have port div_out, input, width 16: FP16 quotient from the divider.
REQ-017 SHALL have port cen_valid, output, width 1: one-cycle centroid result pulse.
REQ-018 SHALL have port cen_idx, output, width clog2(K): cluster index of the result.
REQ-019 SHALL have port cen_value, output, width 16: FP16 new centroid.
REQ-020 SHALL have port cen_empty, output, width 1: the cluster had no usable points.
REQ-021 SHALL have port pass_done, output, width 1: pulse coincident with the last cen_valid of a pass.
REQ-022 SHALL have port cnt_sat, output, width 1: sticky flag, set when any point is dropped on count saturation.

Function
REQ-023 SHALL have FSM states ACCUM, LOAD, DIV, EMIT; ACCUM is entered after reset.
REQ-024 In ACCUM: pt_ready=1; on pt_valid, sum[pt_cluster] += pt_data and cnt[pt_cluster] += 1.
REQ-025 If cnt[pt_cluster] == 2^CNT_W-1, the point SHALL be accepted but not accumulated, and cnt_sat set.
REQ-026 When pass_end and pt_valid coincide in ACCUM, the point SHALL be accumulated first, then the FSM moves to LOAD with idx=0.
REQ-027 pass_end outside ACCUM SHALL be ignored; pt_ready=0 outside ACCUM.
REQ-028 LOAD SHALL register div_in1=fp16(sum[idx]) and div_in2=fp16(cnt[idx]) in one cycle; go to EMIT if cnt==0 or sum==0, else go to DIV.
REQ-029 fp16(x) for x>0: msb position p; exponent 15+p; mantissa = bits below msb, left-aligned to 10 bits, truncated; sign 0; fp16(0)=16'h0000.
REQ-030 DIV SHALL hold div_in1/div_in2 stable and set div_en=1 until div_done=1; on that cycle, capture div_out into cen_value and go to EMIT.
REQ-031 div_en SHALL be 0 in every state except DIV; div_in1/div_in2 SHALL be unchanged from LOAD through the capture cycle.
REQ-032 EMIT SHALL pulse cen_valid for one cycle with cen_idx=idx.
REQ-033 In EMIT for a skipped cluster: cen_value=16'h0000 and cen_empty=1; otherwise cen_empty=0.
REQ-034 EMIT SHALL clear sum[idx] and cnt[idx]; if idx==K-1, pulse pass_done and return to ACCUM, else increment idx and go to LOAD.
REQ-035 Latency per cluster SHALL be LOAD(1) + DIV(divider latency, 2 with the k_8 divider) + EMIT(1) = 4 cycles; a skipped cluster SHALL take 2 cycles.
REQ-036 cen_valid SHALL have no backpressure.

Reset
REQ-037 With rst_n low at a clock edge, the block SHALL clear all sums, counts, idx and cnt_sat, enter ACCUM, and drive 0 on div_in1, div_in2, div_en, cen_valid, cen_idx, cen_value, cen_empty, pass_done and pt_ready (pt_ready=1 from the first cycle after release).
REQ-038 Reset mid-pass (any state) SHALL abort the pass with no further cen_valid.

Structure
REQ-039 Package kmeans_pkg SHALL hold K, PIX_W, CNT_W, SUM_W, FP16_BIAS=15 and the state enum.
REQ-040 Sub-module uint_to_fp16 (combinational, SUM_W-bit input) SHALL implement REQ-029; it is instanced twice.

Verification
REQ-041 Cluster 0: points 100,100,100,100, then pass_end -> div_in1=16'h5E40, div_in2=16'h4400, div_en held until div_done; cen_idx=0.
REQ-042 No points in cluster 3 -> cen_idx=3, cen_value=16'h0000, cen_empty=1, div_en never asserted for idx 3.
REQ-043 Cluster 5: one point value 0 -> skipped (sum==0), cen_empty=1.
REQ-044 256 points into cluster 1 -> cnt=255, cnt_sat=1, div_in2=16'h5BF8.
REQ-045 pass_end with pt_valid in the same cycle -> that point is counted; full pass of 8 non-empty clusters is 32 cycles, and pass_done coincides with cen_idx=7.
REQ-046 rst_n low during DIV -> next cycle div_en=0, state ACCUM, all counts 0.

Source files
------------

// File: rtl/kmeans_pkg.sv
// Shared sizing, FP16 bias and FSM state encoding for the centroid divider feeder.
package kmeans_pkg;
    localparam int K         = 8;
    localparam int PIX_W     = 8;
    localparam int CNT_W     = 8;
    localparam int SUM_W     = 16;
    localparam int FP16_BIAS = 15;

    typedef enum logic [1:0] {ACCUM, LOAD, DIV, EMIT} state_e;
endpackage

// File: rtl/centroid_div_feeder_if.sv
// Point stream, divider handshake and centroid result bundle for centroid_div_feeder.
interface centroid_div_feeder_if #(
    parameter int K     = kmeans_pkg::K,
    parameter int PIX_W = kmeans_pkg::PIX_W
);
    localparam int IDX_W = $clog2(K);

    logic             pt_valid;
    logic [PIX_W-1:0] pt_data;
    logic [IDX_W-1:0] pt_cluster;
    logic             pt_ready;
    logic             pass_end;
    logic [15:0]      div_in1;
    logic [15:0]      div_in2;
    logic             div_en;
    logic             div_done;
    logic [15:0]      div_out;
    logic             cen_valid;
    logic [IDX_W-1:0] cen_idx;
    logic [15:0]      cen_value;
    logic             cen_empty;
    logic             pass_done;
    logic             cnt_sat;

    modport slave (
        input  pt_valid, pt_data, pt_cluster, pass_end, div_done, div_out,
        output pt_ready, div_in1, div_in2, div_en, cen_valid, cen_idx, cen_value,
               cen_empty, pass_done, cnt_sat
    );

    modport master (
        output pt_valid, pt_data, pt_cluster, pass_end, div_done, div_out,
        input  pt_ready, div_in1, div_in2, div_en, cen_valid, cen_idx, cen_value,
               cen_empty, pass_done, cnt_sat
    );
endinterface

// File: rtl/centroid_div_feeder_fp16.sv
// Unsigned integer to FP16 conversion: exponent from msb position, mantissa truncated.
module uint_to_fp16 #(
    parameter int W = kmeans_pkg::SUM_W
) (
    input  logic [W-1:0] x_i,
    output logic [15:0]  fp_o
);
    import kmeans_pkg::*;

    int msb;

    always_comb begin
        msb  = 0;
        fp_o = 16'h0000;
        for (int i = 0; i < W; i++) begin
            if (x_i[i]) msb = i;
        end
        // Shift the leading one to bit W-1, then drop it to keep the 10 bits below it.
        if (x_i != '0) begin
            fp_o = {1'b0, 5'(FP16_BIAS + msb), 10'((x_i << (W - 1 - msb)) >> (W - 11))};
        end
    end
endmodule

// File: rtl/centroid_div_feeder.sv
// Accumulates per-cluster sums/counts, then feeds each cluster through an external FP16 divider.
module centroid_div_feeder #(
    parameter int K     = kmeans_pkg::K,
    parameter int PIX_W = kmeans_pkg::PIX_W,
    parameter int CNT_W = kmeans_pkg::CNT_W,
    parameter int SUM_W = kmeans_pkg::SUM_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    centroid_div_feeder_if.slave  bus
);
    import kmeans_pkg::*;

    localparam int IDX_W = $clog2(K);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q;
    logic [SUM_W-1:0] sum_q [K];
    logic [CNT_W-1:0] cnt_q [K];
    logic [IDX_W-1:0] idx_q;
    logic             pt_ready_q, div_en_q, cen_valid_q, cen_empty_q, pass_done_q, cnt_sat_q;
    logic [15:0]      div_in1_q, div_in2_q, cen_value_q;
    logic [IDX_W-1:0] cen_idx_q;
    logic [15:0]      sum_fp_d, cnt_fp_d;
    logic             accept_d, skip_d, last_d;

    uint_to_fp16 #(.W(SUM_W)) u_sum_fp (.x_i(sum_q[idx_q]), .fp_o(sum_fp_d));
    uint_to_fp16 #(.W(SUM_W)) u_cnt_fp (.x_i(SUM_W'(cnt_q[idx_q])), .fp_o(cnt_fp_d));

    assign accept_d = (state_q == ACCUM) && pt_ready_q && bus.pt_valid;
    assign skip_d   = (cnt_q[idx_q] == '0) || (sum_q[idx_q] == '0);
    assign last_d   = (idx_q == IDX_W'(K - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            idx_q       <= '0;
            pt_ready_q  <= 1'b0;
            div_en_q    <= 1'b0;
            div_in1_q   <= '0;
            div_in2_q   <= '0;
            cen_valid_q <= 1'b0;
            cen_idx_q   <= '0;
            cen_value_q <= '0;
            cen_empty_q <= 1'b0;
            pass_done_q <= 1'b0;
            cnt_sat_q   <= 1'b0;
            for (int k = 0; k < K; k++) begin
                sum_q[k] <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            cen_valid_q <= 1'b0;
            pass_done_q <= 1'b0;
            case (state_q)
                ACCUM: begin
                    pt_ready_q <= !bus.pass_end;
                    if (accept_d) begin
                        if (cnt_q[bus.pt_cluster] == CNT_MAX) begin
                            cnt_sat_q <= 1'b1;
                        end else begin
                            sum_q[bus.pt_cluster] <= sum_q[bus.pt_cluster] + SUM_W'(bus.pt_data);
                            cnt_q[bus.pt_cluster] <= cnt_q[bus.pt_cluster] + CNT_W'(1);
                        end
                    end
                    if (bus.pass_end) begin
                        state_q <= LOAD;
                        idx_q   <= '0;
                    end
                end
                LOAD: begin
                    div_in1_q <= sum_fp_d;
                    div_in2_q <= cnt_fp_d;
                    // Empty or all-zero clusters bypass the divider entirely.
                    if (skip_d) begin
                        state_q     <= EMIT;
                        cen_valid_q <= 1'b1;
                        cen_idx_q   <= idx_q;
                        cen_value_q <= 16'h0000;
                        cen_empty_q <= 1'b1;
                        pass_done_q <= last_d;
                    end else begin
                        state_q  <= DIV;
                        div_en_q <= 1'b1;
                    end
                end
                DIV: begin
                    if (bus.div_done) begin
                        state_q     <= EMIT;
                        div_en_q    <= 1'b0;
                        cen_valid_q <= 1'b1;
                        cen_idx_q   <= idx_q;
                        cen_value_q <= bus.div_out;
                        cen_empty_q <= 1'b0;
                        pass_done_q <= last_d;
                    end
                end
                EMIT: begin
                    sum_q[idx_q] <= '0;
                    cnt_q[idx_q] <= '0;
                    if (last_d) begin
                        state_q    <= ACCUM;
                        pt_ready_q <= 1'b1;
                    end else begin
                        state_q <= LOAD;
                        idx_q   <= idx_q + IDX_W'(1);
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign bus.pt_ready  = pt_ready_q;
    assign bus.div_in1   = div_in1_q;
    assign bus.div_in2   = div_in2_q;
    assign bus.div_en    = div_en_q;
    assign bus.cen_valid = cen_valid_q;
    assign bus.cen_idx   = cen_idx_q;
    assign bus.cen_value = cen_value_q;
    assign bus.cen_empty = cen_empty_q;
    assign bus.pass_done = pass_done_q;
    assign bus.cnt_sat   = cnt_sat_q;
endmodule

// File: tb/tb_centroid_div_feeder.sv
// Randomized and directed bench for centroid_div_feeder with a two-cycle divider stand-in.
module tb_centroid_div_feeder;
    logic clk;
    logic rst_n;
    logic en_d1;

    centroid_div_feeder_if bus ();

    centroid_div_feeder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] div_tag(input logic [15:0] a, input logic [15:0] b);
        return (a ^ {b[7:0], b[15:8]}) + 16'd1;
    endfunction

    // Divider: result valid on the second enabled cycle.
    always @(posedge clk) en_d1 <= bus.div_en;
    assign bus.div_done = bus.div_en & en_d1;
    assign bus.div_out  = div_tag(bus.div_in1, bus.div_in2);

    int n_tests = 0;
    int n_fail  = 0;

    int m_sum [8];
    int m_cnt [8];
    bit m_sat;
    int q_d [$];
    int q_c [$];

    logic [15:0] o_val [8];
    logic [15:0] o_din1 [8];
    logic [15:0] o_din2 [8];
    bit          o_empty [8];
    bit          o_pd [8];
    bit          o_seen [8];
    int          o_en [8];
    bit o_unstable, o_order_bad, o_ready_bad, o_timeout, o_extra, o_ready_after;
    int o_cycles, ev_n;

    function automatic logic [15:0] fp16_ref(input int x);
        int p;
        int m;
        if (x <= 0) return 16'h0000;
        p = 0;
        while ((x >> (p + 1)) != 0) p++;
        m = ((x - (1 << p)) * 1024) >> p;
        return {1'b0, 5'(15 + p), 10'(m)};
    endfunction

    function automatic bit exp_empty(input int k);
        return (m_cnt[k] == 0) || (m_sum[k] == 0);
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 8; k++) begin
            m_sum[k] = 0;
            m_cnt[k] = 0;
        end
    endtask

    task automatic drive_pass();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.pt_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL ready_wait: pt_ready=%b, required 1", bus.pt_ready);
        end
        if (q_d.size() == 0) bus.pass_end = 1'b1;
        for (int i = 0; i < q_d.size(); i++) begin
            if (i > 0) @(negedge clk);
            bus.pt_valid   = 1'b1;
            bus.pt_data    = 8'(q_d[i]);
            bus.pt_cluster = 3'(q_c[i]);
            bus.pass_end   = (i == q_d.size() - 1);
            if (m_cnt[q_c[i]] == 255) m_sat = 1'b1;
            else begin
                m_sum[q_c[i]] += q_d[i];
                m_cnt[q_c[i]] += 1;
            end
        end
    endtask

    task automatic collect_pass();
        logic [15:0] h1, h2;
        h1 = '0;
        h2 = '0;
        for (int k = 0; k < 8; k++) begin
            o_val[k] = 'x; o_din1[k] = 'x; o_din2[k] = 'x;
            o_empty[k] = 0; o_pd[k] = 0; o_seen[k] = 0; o_en[k] = 0;
        end
        {o_unstable, o_order_bad, o_ready_bad, o_extra} = '0;
        o_timeout = 1'b1;
        o_cycles  = -1;
        ev_n      = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            bus.pt_valid = 1'b0;
            bus.pass_end = 1'b0;
            if (bus.pt_ready !== 1'b0) o_ready_bad = 1'b1;
            if (bus.div_en === 1'b1 && ev_n < 8) begin
                if (o_en[ev_n] == 0) begin
                    h1 = bus.div_in1;
                    h2 = bus.div_in2;
                end else if (bus.div_in1 !== h1 || bus.div_in2 !== h2) o_unstable = 1'b1;
                o_en[ev_n]++;
            end
            if (bus.cen_valid === 1'b1) begin
                if (ev_n < 8) begin
                    if (int'(bus.cen_idx) != ev_n) o_order_bad = 1'b1;
                    o_seen[ev_n]  = 1'b1;
                    o_val[ev_n]   = bus.cen_value;
                    o_empty[ev_n] = bus.cen_empty;
                    o_pd[ev_n]    = bus.pass_done;
                    o_din1[ev_n]  = bus.div_in1;
                    o_din2[ev_n]  = bus.div_in2;
                end
                ev_n++;
                if (bus.pass_done === 1'b1) begin
                    o_cycles  = c + 1;
                    o_timeout = 1'b0;
                    break;
                end
            end else if (bus.pass_done !== 1'b0) o_order_bad = 1'b1;
        end
        @(negedge clk);
        o_extra       = (bus.cen_valid !== 1'b0);
        o_ready_after = (bus.pt_ready === 1'b1);
    endtask

    task automatic test_reset();
        logic [56:0] v;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        v = {bus.div_in1, bus.div_in2, bus.div_en, bus.cen_valid, bus.cen_idx, bus.cen_value,
             bus.cen_empty, bus.pass_done, bus.pt_ready, bus.cnt_sat};
        n_tests++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 0", v);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.pt_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b, required 1", bus.pt_ready);
        end
        n_tests++;
        if (bus.cen_valid !== 1'b0 || bus.div_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: cen_valid=%b div_en=%b, required 0 0", bus.cen_valid, bus.div_en);
        end
    endtask

    task automatic test_directed();
        q_d = {100, 100, 100, 100, 0, 9};
        q_c = {0, 0, 0, 0, 5, 7};
        drive_pass();
        collect_pass();
        n_tests++;
        if (o_din1[0] !== 16'h5E40 || o_din2[0] !== 16'h4400) begin
            n_fail++;
            $display("FAIL dir_c0_din: got %h/%h, required 5e40/4400", o_din1[0], o_din2[0]);
        end
        n_tests++;
        if (o_en[0] != 2 || o_val[0] !== div_tag(16'h5E40, 16'h4400) || o_empty[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL dir_c0_result: en=%0d val=%h empty=%b, required 2 %h 0", o_en[0], o_val[0],
                     div_tag(16'h5E40, 16'h4400), o_empty[0]);
        end
        n_tests++;
        if (!o_seen[3] || o_val[3] !== 16'h0000 || o_empty[3] !== 1'b1 || o_en[3] != 0) begin
            n_fail++;
            $display("FAIL dir_c3_empty: seen=%b val=%h empty=%b en=%0d, required 1 0000 1 0", o_seen[3], o_val[3],
                     o_empty[3], o_en[3]);
        end
        n_tests++;
        if (o_val[5] !== 16'h0000 || o_empty[5] !== 1'b1 || o_en[5] != 0) begin
            n_fail++;
            $display("FAIL dir_c5_zero_sum: val=%h empty=%b en=%0d, required 0000 1 0", o_val[5], o_empty[5], o_en[5]);
        end
        n_tests++;
        if (o_din2[7] !== 16'h3C00 || o_empty[7] !== 1'b0 || o_pd[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL dir_pass_end_point: din2=%h empty=%b pass_done=%b, required 3c00 0 1", o_din2[7], o_empty[7], o_pd[7]);
        end
        n_tests++;
        if (o_timeout || o_cycles != 20 || o_order_bad || o_unstable) begin
            n_fail++;
            $display("FAIL dir_timing: cycles=%0d timeout=%b order=%b unstable=%b, required 20 0 0 0", o_cycles,
                     o_timeout, o_order_bad, o_unstable);
        end
        clear_model();
    endtask

    task automatic test_saturation();
        n_tests++;
        if (bus.cnt_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_initial: cnt_sat=%b, required 0", bus.cnt_sat);
        end
        q_d.delete();
        q_c.delete();
        for (int i = 0; i < 256; i++) begin
            q_d.push_back(200);
            q_c.push_back(1);
        end
        drive_pass();
        collect_pass();
        n_tests++;
        if (o_din2[1] !== 16'h5BF8) begin
            n_fail++;
            $display("FAIL sat_count: din2=%h, required 5bf8", o_din2[1]);
        end
        n_tests++;
        if (o_din1[1] !== fp16_ref(m_sum[1])) begin
            n_fail++;
            $display("FAIL sat_sum: din1=%h, required %h", o_din1[1], fp16_ref(m_sum[1]));
        end
        n_tests++;
        if (bus.cnt_sat !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_flag: cnt_sat=%b, required 1", bus.cnt_sat);
        end
        clear_model();
    endtask

    task automatic test_random_passes();
        logic [15:0] ev;
        bit emp;
        for (int p = 0; p < 4; p++) begin
            q_d.delete();
            q_c.delete();
            if (p == 0) begin
                for (int k = 0; k < 8; k++) begin
                    q_d.push_back(1 + $urandom_range(254));
                    q_c.push_back(k);
                end
                repeat ($urandom_range(12)) begin
                    q_d.push_back($urandom_range(255));
                    q_c.push_back($urandom_range(7));
                end
            end else begin
                repeat ($urandom_range(24)) begin
                    q_d.push_back(($urandom_range(3) == 0) ? 0 : $urandom_range(255));
                    q_c.push_back($urandom_range(7));
                end
            end
            drive_pass();
            collect_pass();
            for (int k = 0; k < 8; k++) begin
                emp = exp_empty(k);
                ev  = emp ? 16'h0000 : div_tag(fp16_ref(m_sum[k]), fp16_ref(m_cnt[k]));
                n_tests++;
                if (!o_seen[k] || o_val[k] !== ev || o_empty[k] !== emp) begin
                    n_fail++;
                    $display("FAIL rnd%0d_result[%0d]: seen=%b val=%h empty=%b, required 1 %h %b", p, k, o_seen[k],
                             o_val[k], o_empty[k], ev, emp);
                end
                n_tests++;
                if (o_pd[k] !== (k == 7) || o_en[k] != (emp ? 0 : 2)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_ctrl[%0d]: pass_done=%b div_en_cycles=%0d, required %b %0d", p, k, o_pd[k],
                             o_en[k], (k == 7), emp ? 0 : 2);
                end
                if (!emp) begin
                    n_tests++;
                    if (o_din1[k] !== fp16_ref(m_sum[k]) || o_din2[k] !== fp16_ref(m_cnt[k])) begin
                        n_fail++;
                        $display("FAIL rnd%0d_din[%0d]: got %h/%h, required %h/%h", p, k, o_din1[k], o_din2[k],
                                 fp16_ref(m_sum[k]), fp16_ref(m_cnt[k]));
                    end
                end
            end
            n_tests++;
            if ({o_timeout, o_order_bad, o_unstable, o_ready_bad, o_extra} !== 5'b0 || !o_ready_after || ev_n != 8) begin
                n_fail++;
                $display("FAIL rnd%0d_flow: timeout/order/unstable/ready/extra=%b ready_after=%b events=%0d, required 00000 1 8",
                         p, {o_timeout, o_order_bad, o_unstable, o_ready_bad, o_extra}, o_ready_after, ev_n);
            end
            n_tests++;
            if (bus.cnt_sat !== m_sat) begin
                n_fail++;
                $display("FAIL rnd%0d_cnt_sat: got %b, required %b", p, bus.cnt_sat, m_sat);
            end
            if (p == 0) begin
                n_tests++;
                if (o_cycles != 32) begin
                    n_fail++;
                    $display("FAIL rnd_full_pass_cycles: got %0d, required 32", o_cycles);
                end
            end
            clear_model();
        end
    endtask

    task automatic test_reset_mid_div();
        bit hit;
        int stray;
        q_d = {50, 77};
        q_c = {4, 6};
        drive_pass();
        hit = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            bus.pt_valid = 1'b0;
            bus.pass_end = 1'b0;
            if (bus.div_en === 1'b1) begin
                hit = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL rstdiv_reach_div: div_en never seen, required 1");
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.div_en !== 1'b0 || bus.cen_valid !== 1'b0 || bus.pt_ready !== 1'b0 || bus.cnt_sat !== 1'b0) begin
            n_fail++;
            $display("FAIL rstdiv_outputs: div_en=%b cen_valid=%b pt_ready=%b cnt_sat=%b, required 0 0 0 0", bus.div_en,
                     bus.cen_valid, bus.pt_ready, bus.cnt_sat);
        end
        rst_n = 1'b1;
        m_sat = 1'b0;
        clear_model();
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.cen_valid !== 1'b0) stray++;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL rstdiv_no_result: cen_valid cycles=%0d, required 0", stray);
        end
        q_d = {7};
        q_c = {2};
        drive_pass();
        collect_pass();
        n_tests++;
        if (o_din1[2] !== fp16_ref(7) || o_din2[2] !== 16'h3C00) begin
            n_fail++;
            $display("FAIL rstdiv_counts_cleared: din=%h/%h, required %h/3c00", o_din1[2], o_din2[2], fp16_ref(7));
        end
        n_tests++;
        if (o_empty[4] !== 1'b1 || o_empty[6] !== 1'b1 || o_cycles != 18) begin
            n_fail++;
            $display("FAIL rstdiv_old_pass_gone: empty4=%b empty6=%b cycles=%0d, required 1 1 18", o_empty[4], o_empty[6],
                     o_cycles);
        end
        clear_model();
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.pt_valid   = 1'b0;
        bus.pt_data    = '0;
        bus.pt_cluster = '0;
        bus.pass_end   = 1'b0;
        m_sat          = 1'b0;
        clear_model();
        test_reset();
        test_directed();
        test_saturation();
        test_random_passes();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
